down_counter: RTL and testbench

//  Clock-enabled down counter, the counterpart of the ripple up counter on the DE1_SoC board.

---
 rtl/down_counter_pkg.sv | 27 ++
 rtl/down_counter_seg7_decode.sv | 19 +
 rtl/down_counter.sv | 141 ++++++++++++++
 tb/tb_down_counter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_counter_pkg.sv
// ============================================================================
// Module      : down_counter_pkg
// Description : Shared state encoding and active-low 7-segment lookup table
//               for the down_counter block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Segment order is gfedcba, active-low; index is the hex digit 0-F.
    localparam logic [6:0] SEG7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/down_counter_seg7_decode.sv
// ============================================================================
// Module      : seg7_decode
// Description : Combinational 4-bit to active-low 7-segment (gfedcba) decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import down_counter_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = SEG7[i_digit];

endmodule

`default_nettype wire

// File: rtl/down_counter.sv
// ============================================================================
// Module      : down_counter
// Description : Clock-enabled down counter stepped by rising edges of a
//               divided-clock bit, with load, run/pause and terminal count.
//               Optional registered HEX output when DOWN_COUNTER_HEX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int STOP_AT_ZERO = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             rate_in,
    input  logic             run,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc_pulse
`ifdef DOWN_COUNTER_HEX_EN
    ,
    output logic [6:0]       hex
`endif
);

    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    logic             r_rate_q;
    logic             w_tick;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_tc;
    logic             w_tc_nxt;

    // rate_q resets high so a rate_in already high at release is not a tick.
    assign w_tick = rate_in & ~r_rate_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rate_q <= 1'b1;
            r_state  <= IDLE;
            r_count  <= c_MAX;
            r_tc     <= 1'b0;
        end else begin
            r_rate_q <= rate_in;
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        if (load) begin
            w_count_nxt = load_val;
            if (r_state == HALT) begin
                w_state_nxt = IDLE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (run) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        w_state_nxt = IDLE;
                    end else if (w_tick) begin
                        if (r_count != '0) begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end else begin
                            w_tc_nxt = 1'b1;
                            if (STOP_AT_ZERO != 0) begin
                                w_state_nxt = HALT;
                            end else begin
                                w_count_nxt = c_MAX;
                            end
                        end
                    end
                end
                HALT: begin
                    if (!run) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign count    = r_count;
    assign zero     = (r_count == '0);
    assign tc_pulse = r_tc;

`ifdef DOWN_COUNTER_HEX_EN
    localparam logic [3:0] c_RESET_NIB = (WIDTH >= 4) ? 4'hF : 4'((1 << WIDTH) - 1);

    logic [3:0] w_nib;
    logic [6:0] w_seg;
    logic [6:0] r_hex;

    // Narrow counters are zero-extended to a full hex digit.
    generate
        if (WIDTH >= 4) begin : g_nib_full
            assign w_nib = r_count[3:0];
        end else begin : g_nib_pad
            assign w_nib = {{(4 - WIDTH){1'b0}}, r_count};
        end
    endgenerate

    seg7_decode u_seg7_decode (
        .i_digit (w_nib),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hex <= SEG7[c_RESET_NIB];
        end else begin
            r_hex <= w_seg;
        end
    end

    assign hex = r_hex;
`endif

endmodule

`default_nettype wire

// File: tb/tb_down_counter.sv
// ============================================================================
// Module      : tb_down_counter
// Description : Directed self-checking bench for down_counter (wrapping and
//               stop-at-zero instances driven by the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_counter;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       rate_in  = 1'b1;
    logic       run      = 1'b0;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] count, count_s;
    logic       zero, zero_s;
    logic       tc_pulse, tc_s;
`ifdef DOWN_COUNTER_HEX_EN
    logic [6:0] hex, hex_s;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    down_counter #(.WIDTH(4), .STOP_AT_ZERO(0)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rate_in  (rate_in),
        .run      (run),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .zero     (zero),
        .tc_pulse (tc_pulse)
`ifdef DOWN_COUNTER_HEX_EN
        ,
        .hex      (hex)
`endif
    );

    down_counter #(.WIDTH(4), .STOP_AT_ZERO(1)) dut_s (
        .clock    (clock),
        .reset_n  (reset_n),
        .rate_in  (rate_in),
        .run      (run),
        .load     (load),
        .load_val (load_val),
        .count    (count_s),
        .zero     (zero_s),
        .tc_pulse (tc_s)
`ifdef DOWN_COUNTER_HEX_EN
        ,
        .hex      (hex_s)
`endif
    );

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        rate_in = 1'b1;
        run     = 1'b0;
        load    = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Raise rate_in and return at the negedge after the edge that takes the tick.
    task automatic tick_rise();
        rate_in = 1'b1;
        @(negedge clock);
    endtask

    task automatic tick_fall();
        rate_in = 1'b0;
        @(negedge clock);
    endtask

    task automatic start_running();
        rate_in = 1'b0;
        run     = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (count !== 4'd15 || zero !== 1'b0 || tc_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got count=%0d zero=%b tc=%b expected count=15 zero=0 tc=0", i, count, zero, tc_pulse);
            end
        end
`ifdef DOWN_COUNTER_HEX_EN
        checks++;
        if (hex !== 7'h0E) begin
            errors++;
            $display("FAIL reset_hex: got %h expected 0e", hex);
        end
`endif
    endtask

    task automatic test_countdown();
        do_reset();
        start_running();
        for (int i = 0; i < 3; i++) begin
            tick_rise();
            checks++;
            if (count !== 4'(14 - i)) begin
                errors++;
                $display("FAIL countdown_step[%0d]: got %0d expected %0d", i, count, 14 - i);
            end
            @(negedge clock);
            checks++;
            if (count !== 4'(14 - i)) begin
                errors++;
                $display("FAIL countdown_high_hold[%0d]: got %0d expected %0d", i, count, 14 - i);
            end
            tick_fall();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rate_in  = 1'b0;
        load_val = 4'd1;
        load     = 1'b1;
        @(negedge clock);
        load = 1'b0;
        checks++;
        if (count !== 4'd1) begin
            errors++;
            $display("FAIL wrap_load: got %0d expected 1", count);
        end
        start_running();
        tick_rise();
        checks++;
        if (count !== 4'd0 || zero !== 1'b1 || tc_pulse !== 1'b0) begin
            errors++;
            $display("FAIL wrap_to_zero: got count=%0d zero=%b tc=%b expected count=0 zero=1 tc=0", count, zero, tc_pulse);
        end
        tick_fall();
        tick_rise();
        checks++;
        if (count !== 4'd15 || zero !== 1'b0 || tc_pulse !== 1'b1) begin
            errors++;
            $display("FAIL wrap_tc: got count=%0d zero=%b tc=%b expected count=15 zero=0 tc=1", count, zero, tc_pulse);
        end
        tick_fall();
        checks++;
        if (tc_pulse !== 1'b0) begin
            errors++;
            $display("FAIL wrap_tc_single: got tc=%b expected 0", tc_pulse);
        end
    endtask

    task automatic test_stop_at_zero();
        do_reset();
        rate_in  = 1'b0;
        load_val = 4'd1;
        load     = 1'b1;
        @(negedge clock);
        load = 1'b0;
        start_running();
        tick_rise();
        tick_fall();
        tick_rise();
        checks++;
        if (count_s !== 4'd0 || zero_s !== 1'b1 || tc_s !== 1'b1) begin
            errors++;
            $display("FAIL stop_tc: got count=%0d zero=%b tc=%b expected count=0 zero=1 tc=1", count_s, zero_s, tc_s);
        end
        tick_fall();
        checks++;
        if (tc_s !== 1'b0) begin
            errors++;
            $display("FAIL stop_tc_single: got tc=%b expected 0", tc_s);
        end
        for (int i = 0; i < 5; i++) begin
            tick_rise();
            checks++;
            if (count_s !== 4'd0 || tc_s !== 1'b0) begin
                errors++;
                $display("FAIL stop_halt[%0d]: got count=%0d tc=%b expected count=0 tc=0", i, count_s, tc_s);
            end
            tick_fall();
        end
        load_val = 4'd9;
        load     = 1'b1;
        @(negedge clock);
        load = 1'b0;
        checks++;
        if (count_s !== 4'd9 || tc_s !== 1'b0) begin
            errors++;
            $display("FAIL stop_reload: got count=%0d tc=%b expected count=9 tc=0", count_s, tc_s);
        end
        // Back in IDLE: this tick lands on the IDLE->RUN edge and is ignored.
        tick_rise();
        checks++;
        if (count_s !== 4'd9) begin
            errors++;
            $display("FAIL stop_idle_tick: got %0d expected 9", count_s);
        end
        tick_fall();
        tick_rise();
        checks++;
        if (count_s !== 4'd8) begin
            errors++;
            $display("FAIL stop_resume: got %0d expected 8", count_s);
        end
        tick_fall();
    endtask

    task automatic test_load_tick();
        do_reset();
        start_running();
        load_val = 4'd6;
        load     = 1'b1;
        rate_in  = 1'b1;
        @(negedge clock);
        load = 1'b0;
        checks++;
        if (count !== 4'd6 || tc_pulse !== 1'b0) begin
            errors++;
            $display("FAIL load_tick: got count=%0d tc=%b expected count=6 tc=0", count, tc_pulse);
        end
        @(negedge clock);
        checks++;
        if (count !== 4'd6) begin
            errors++;
            $display("FAIL load_tick_hold: got %0d expected 6", count);
        end
        tick_fall();
        tick_rise();
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL load_then_tick: got %0d expected 5", count);
        end
        tick_fall();
        load_val = 4'd3;
        load     = 1'b1;
        @(negedge clock);
        tick_rise();
        tick_fall();
        tick_rise();
        checks++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL load_held: got %0d expected 3", count);
        end
        tick_fall();
        load_val = 4'd0;
        @(negedge clock);
        load = 1'b0;
        checks++;
        if (count !== 4'd0 || zero !== 1'b1 || tc_pulse !== 1'b0) begin
            errors++;
            $display("FAIL load_zero: got count=%0d zero=%b tc=%b expected count=0 zero=1 tc=0", count, zero, tc_pulse);
        end
        @(negedge clock);
        checks++;
        if (tc_pulse !== 1'b0) begin
            errors++;
            $display("FAIL load_zero_tc: got tc=%b expected 0", tc_pulse);
        end
    endtask

    task automatic test_run_pause();
        do_reset();
        start_running();
        tick_rise();
        tick_fall();
        run = 1'b0;
        tick_rise();
        checks++;
        if (count !== 4'd14) begin
            errors++;
            $display("FAIL pause_drop: got %0d expected 14", count);
        end
        tick_fall();
        run     = 1'b1;
        rate_in = 1'b1;
        @(negedge clock);
        checks++;
        if (count !== 4'd14) begin
            errors++;
            $display("FAIL run_rise_tick: got %0d expected 14", count);
        end
        tick_fall();
        tick_rise();
        checks++;
        if (count !== 4'd13) begin
            errors++;
            $display("FAIL run_resume: got %0d expected 13", count);
        end
        tick_fall();
    endtask

`ifdef DOWN_COUNTER_HEX_EN
    task automatic test_hex();
        do_reset();
        rate_in  = 1'b0;
        load_val = 4'd0;
        load     = 1'b1;
        @(negedge clock);
        load = 1'b0;
        checks++;
        if (hex !== 7'h0E) begin
            errors++;
            $display("FAIL hex_lag: got %h expected 0e", hex);
        end
        @(negedge clock);
        checks++;
        if (hex !== 7'b1000000) begin
            errors++;
            $display("FAIL hex_zero: got %b expected 1000000", hex);
        end
        load_val = 4'd10;
        load     = 1'b1;
        @(negedge clock);
        load = 1'b0;
        @(negedge clock);
        checks++;
        if (hex !== 7'b0001000) begin
            errors++;
            $display("FAIL hex_a: got %b expected 0001000", hex);
        end
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        start_running();
        tick_rise();
        tick_fall();
        tick_rise();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 4'd15 || count_s !== 4'd15 || tc_pulse !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d count_s=%0d tc=%b expected 15 15 0", count, count_s, tc_pulse);
        end
`ifdef DOWN_COUNTER_HEX_EN
        checks++;
        if (hex !== 7'h0E) begin
            errors++;
            $display("FAIL async_reset_hex: got %h expected 0e", hex);
        end
`endif
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (count !== 4'd15) begin
            errors++;
            $display("FAIL async_release: got %0d expected 15", count);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_wrap();
        test_stop_at_zero();
        test_load_tick();
        test_run_pause();
`ifdef DOWN_COUNTER_HEX_EN
        test_hex();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
